fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and drives a synchronous-read instruction memory.
- Delivers the fetched instruction and PC+4 to the decode stage. inst_out[15:0] is the immediate field that feeds the decode-stage sign extender.
- Handles hazard stalls, branch/jump redirects and HALT detection.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_pc_reg.sv | 30 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: NOP and HALT encodings,
// FSM state encodings and the PC increment.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST          = 32'h0000_0000;
    localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register.
// Ports: clk, reset (sync, active-high), load (pc <= target+4),
//        inc (pc <= pc+4), target (redirect address), pc (current PC).
// Priority: reset > load > inc > hold. Arithmetic wraps modulo 2^PC_WIDTH.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                inc,
    input  logic [PC_WIDTH-1:0] target,
    output logic [PC_WIDTH-1:0] pc
);

    // Redirect loads target+4 because the target itself is fetched this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target + PC_WIDTH'(PC_INC);
        end else if (inc) begin
            pc <= pc + PC_WIDTH'(PC_INC);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Optional feature: define FETCH_COUNT_EN to add the fetch_count output.
// Ports:
//   clk, reset (sync, active-high), enable (global run), stall (hazard hold),
//   flush + branch_target (redirect), imem_addr/imem_en/imem_data (sync-read
//   instruction memory, one-cycle latency), inst_out/pc_plus4_out/valid_out
//   (IF/ID register), halted (HALT instruction reached),
//   fetch_count (FETCH_COUNT_EN only: number of valid instructions delivered).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned            PC_WIDTH   = 32,
    parameter int unsigned            INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0]  HALT_INST  = INST_WIDTH'(HALT_INST_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   branch_target,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic                  imem_en,
    input  logic [INST_WIDTH-1:0] imem_data,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [PC_WIDTH-1:0]   pc_plus4_out,
    output logic                  valid_out,
    output logic                  halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    localparam logic [INST_WIDTH-1:0] NOP_W = INST_WIDTH'(NOP_INST);

    logic [PC_WIDTH-1:0]   pc;
    logic                  pc_load;
    logic                  pc_inc;

    logic [1:0]            state_q,      state_n;
    logic [PC_WIDTH-1:0]   fetch_pc_q,   fetch_pc_n;
    logic                  pend_q,       pend_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [PC_WIDTH-1:0]   pc_plus4_n;
    logic                  valid_n;
    logic                  halted_n;
`ifdef FETCH_COUNT_EN
    logic [31:0]           fetch_count_n;
`endif

    // Flush wins over stall and over HALT; enable gates everything.
    assign pc_load   = enable & flush;
    assign pc_inc    = enable & ~flush & ~stall & (state_q != ST_HALT);
    assign imem_addr = flush ? branch_target : pc;
    assign imem_en   = enable & (flush | (~stall & (state_q != ST_HALT)));

    pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (branch_target),
        .pc     (pc)
    );

    // Next-state and IF/ID next-value logic.
    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        pend_n     = pend_q;
        inst_n     = inst_out;
        pc_plus4_n = pc_plus4_out;
        valid_n    = valid_out;
        halted_n   = halted;
`ifdef FETCH_COUNT_EN
        fetch_count_n = fetch_count;
`endif
        if (enable) begin
            if (flush) begin
                fetch_pc_n = branch_target;
                pend_n     = 1'b1;
                inst_n     = NOP_W;
                valid_n    = 1'b0;
                halted_n   = 1'b0;
                state_n    = ST_RUN;
            end else if (!stall) begin
                if (state_q == ST_HALT) begin
                    // Drain the captured HALT into a bubble and stay there.
                    inst_n  = NOP_W;
                    valid_n = 1'b0;
                end else begin
                    fetch_pc_n = pc;
                    pend_n     = 1'b1;
                    state_n    = ST_RUN;
                    if (pend_q) begin
                        inst_n     = imem_data;
                        pc_plus4_n = fetch_pc_q + PC_WIDTH'(PC_INC);
                        valid_n    = 1'b1;
`ifdef FETCH_COUNT_EN
                        fetch_count_n = fetch_count + 32'd1;
`endif
                        if (imem_data == HALT_INST) begin
                            state_n  = ST_HALT;
                            halted_n = 1'b1;
                            pend_n   = 1'b0;
                        end
                    end else begin
                        inst_n  = NOP_W;
                        valid_n = 1'b0;
                    end
                end
            end
        end
    end

    // State and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= '0;
            pend_q       <= 1'b0;
            inst_out     <= NOP_W;
            pc_plus4_out <= '0;
            valid_out    <= 1'b0;
            halted       <= 1'b0;
`ifdef FETCH_COUNT_EN
            fetch_count  <= 32'd0;
`endif
        end else begin
            state_q      <= state_n;
            fetch_pc_q   <= fetch_pc_n;
            pend_q       <= pend_n;
            inst_out     <= inst_n;
            pc_plus4_out <= pc_plus4_n;
            valid_out    <= valid_n;
            halted       <= halted_n;
`ifdef FETCH_COUNT_EN
            fetch_count  <= fetch_count_n;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural synchronous-read memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] inst_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    logic        halt_armed = 1'b0;
    int          tests = 0;
    int          fails = 0;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_data     (imem_data),
        .inst_out      (inst_out),
        .pc_plus4_out  (pc_plus4_out),
        .valid_out     (valid_out),
        .halted        (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: two known words at 0/4, optional HALT at 0x10,
    // otherwise an address-tagged word.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
        if (a == 32'h0)             return 32'h2001_0005;
        if (a == 32'h4)             return 32'h2002_0007;
        if (a == 32'h10 && h)       return 32'hFFFF_FFFF;
        return {16'hA000, a[15:0]};
    endfunction

    // Read data holds while imem_en is low.
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem_word(imem_addr, halt_armed);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] p4,
                            input logic v);
        chk({tag, ".inst"}, inst_out, i);
        chk({tag, ".pc4"}, pc_plus4_out, p4);
        chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, v});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 32'h0;
        tick(); tick();
        // Reset state
        chk_ifid("reset", 32'h0, 32'h0, 1'b0);
        chk("reset.halted", {31'b0, halted}, 32'h0);
        chk("reset.addr", imem_addr, 32'h0);
`ifdef FETCH_COUNT_EN
        chk("reset.count", fetch_count, 32'h0);
`endif

        // Startup fetch: cycle 0 presents address 0
        reset = 1'b0; enable = 1'b1;
        #1;
        chk("c0.addr", imem_addr, 32'h0);
        chk("c0.en", {31'b0, imem_en}, 32'h1);
        chk("c0.valid", {31'b0, valid_out}, 32'h0);
        tick();
        chk("c1.valid", {31'b0, valid_out}, 32'h0);
        tick();
        chk_ifid("c2", 32'h2001_0005, 32'h4, 1'b1);
        tick();
        chk_ifid("c3", 32'h2002_0007, 32'h8, 1'b1);

        // Stall three cycles while the fetch of 0x8 is pending
        stall = 1'b1;
        #1;
        chk("stall.en", {31'b0, imem_en}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall.hold", 32'h2002_0007, 32'h8, 1'b1);
            chk("stall.en2", {31'b0, imem_en}, 32'h0);
        end
        stall = 1'b0;
        tick();
        chk_ifid("stall.rel", 32'hA000_0008, 32'hC, 1'b1);
        tick();
        chk_ifid("stall.next", 32'hA000_000C, 32'h10, 1'b1);

        // Flush with simultaneous stall
        flush = 1'b1; stall = 1'b1; branch_target = 32'h40;
        #1;
        chk("flush.addr", imem_addr, 32'h40);
        chk("flush.en", {31'b0, imem_en}, 32'h1);
        tick();
        flush = 1'b0; stall = 1'b0;
        chk("flush.valid", {31'b0, valid_out}, 32'h0);
        tick();
        chk_ifid("flush.tgt", 32'hA000_0040, 32'h44, 1'b1);

        // HALT at 0x10 reached through a redirect
        halt_armed = 1'b1;
        flush = 1'b1; branch_target = 32'h10;
        tick();
        flush = 1'b0;
        chk("halt.bubble", {31'b0, valid_out}, 32'h0);
        tick();
        chk_ifid("halt.cap", 32'hFFFF_FFFF, 32'h14, 1'b1);
        chk("halt.halted", {31'b0, halted}, 32'h1);
        chk("halt.en", {31'b0, imem_en}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt.nop", inst_out, 32'h0);
            chk("halt.nv", {31'b0, valid_out}, 32'h0);
            chk("halt.stay", {31'b0, halted}, 32'h1);
            chk("halt.en2", {31'b0, imem_en}, 32'h0);
        end
        halt_armed = 1'b0;
        flush = 1'b1; branch_target = 32'h0;
        #1;
        chk("unhalt.en", {31'b0, imem_en}, 32'h1);
        tick();
        flush = 1'b0;
        chk("unhalt.halted", {31'b0, halted}, 32'h0);
        chk("unhalt.valid", {31'b0, valid_out}, 32'h0);
        tick();
        chk_ifid("unhalt.res", 32'h2001_0005, 32'h4, 1'b1);

        // Freeze: enable low, flush ignored
        enable = 1'b0; flush = 1'b1; branch_target = 32'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ifid("freeze", 32'h2001_0005, 32'h4, 1'b1);
            chk("freeze.en", {31'b0, imem_en}, 32'h0);
        end

        // Wrap across the top of the address space
        enable = 1'b1; branch_target = 32'hFFFF_FFF8;
        tick();
        flush = 1'b0;
        #1;
        chk("wrap.addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk_ifid("wrap.i1", 32'hA000_FFF8, 32'hFFFF_FFFC, 1'b1);
        chk("wrap.addr0", imem_addr, 32'h0);
        tick();
        chk_ifid("wrap.i2", 32'hA000_FFFC, 32'h0, 1'b1);

        // Reset during a stall at pc=0x24
        flush = 1'b1; branch_target = 32'h1C;
        tick();
        flush = 1'b0;
        tick();
        chk_ifid("pre.rst", 32'hA000_001C, 32'h20, 1'b1);
        stall = 1'b1;
        #1;
        chk("pre.addr", imem_addr, 32'h24);
`ifdef FETCH_COUNT_EN
        chk("pre.count", fetch_count, 32'd10);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0; enable = 1'b0;
        #1;
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.valid", {31'b0, valid_out}, 32'h0);
        chk("rst.halted", {31'b0, halted}, 32'h0);
        chk("rst.inst", inst_out, 32'h0);
`ifdef FETCH_COUNT_EN
        chk("rst.count", fetch_count, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
